// File: rtl/xyolo_write_pkg.sv
// Shared widths, FSM states and latched schedule configuration for the YOLO write-back unit.
package xyolo_write_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned PERIOD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DLY,
        ST_XFER,
        ST_DONE
    } state_e;

    // Schedule held for the whole run; period/duty are stored already normalised.
    typedef struct packed {
        logic [ADDR_W-1:0]   iterations;
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] duty;
        logic [PERIOD_W-1:0] delay;
        logic [ADDR_W-1:0]   incr;
        logic [ADDR_W-1:0]   shift;
    } sched_cfg_t;

    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period);
        return (period == '0) ? PERIOD_W'(1) : period;
    endfunction

endpackage

// File: rtl/xyolo_write_if.sv
// Flow-in, configuration and memory write port bundle of the YOLO write-back unit.
interface xyolo_write_if;
    import xyolo_write_pkg::*;

    logic                run;
    logic                pause;
    logic [DATA_W-1:0]   flow_in;
    logic [ADDR_W-1:0]   iterations;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] duty;
    logic [PERIOD_W-1:0] delay;
    logic [ADDR_W-1:0]   start;
    logic [ADDR_W-1:0]   incr;
    logic [ADDR_W-1:0]   shift;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                busy;
    logic                done;

    modport master (
        output run, pause, flow_in, iterations, period, duty, delay, start, incr, shift,
        input  mem_en, mem_addr, mem_data, busy, done
    );

    modport slave (
        input  run, pause, flow_in, iterations, period, duty, delay, start, incr, shift,
        output mem_en, mem_addr, mem_data, busy, done
    );

endinterface

// File: rtl/xwrite_sched.sv
// Delay / phase / iteration counters and address accumulator for the write-back schedule.
module xwrite_sched
    import xyolo_write_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              dly_en_i,
    input  logic              xfer_en_i,
    input  logic [ADDR_W-1:0] start_i,
    input  sched_cfg_t        cfg_i,
    output logic              dly_end_c,
    output logic              sample_c,
    output logic              last_c,
    output logic [ADDR_W-1:0] addr_o
);

    logic [PERIOD_W-1:0] dly_q, dly_d;
    logic [PERIOD_W-1:0] p_q, p_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                p_end_c;
    logic                final_p_c;

    // With duty=0 nothing is written, so the schedule ends on the last phase of the last period.
    always_comb begin
        p_end_c   = (p_q == cfg_i.period - PERIOD_W'(1));
        final_p_c = (cfg_i.duty == '0) ? p_end_c : (p_q == cfg_i.duty - PERIOD_W'(1));
        sample_c  = xfer_en_i && (p_q < cfg_i.duty);
        dly_end_c = dly_en_i && (dly_q == cfg_i.delay - PERIOD_W'(1));
        last_c    = xfer_en_i && (i_q == cfg_i.iterations - ADDR_W'(1)) && final_p_c;

        dly_d  = dly_q;
        p_d    = p_q;
        i_d    = i_q;
        addr_d = addr_q;
        if (load_i) begin
            dly_d  = '0;
            p_d    = '0;
            i_d    = '0;
            addr_d = start_i;
        end else if (dly_en_i) begin
            dly_d = dly_q + PERIOD_W'(1);
        end else if (xfer_en_i) begin
            addr_d = addr_q + (sample_c ? cfg_i.incr : '0) + (p_end_c ? cfg_i.shift : '0);
            if (p_end_c) begin
                p_d = '0;
                i_d = i_q + ADDR_W'(1);
            end else begin
                p_d = p_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q  <= '0;
            p_q    <= '0;
            i_q    <= '0;
            addr_q <= '0;
        end else begin
            dly_q  <= dly_d;
            p_q    <= p_d;
            i_q    <= i_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/xyolo_write.sv
// Versat YOLO write-back: samples flow_in on a delay/period/duty schedule and drives a
// registered memory write port with start/incr/shift addressing.
module xyolo_write
    import xyolo_write_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    xyolo_write_if.slave bus
);

    state_e            state_q;
    sched_cfg_t        cfg_q, cfg_d;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              busy_q;
    logic              done_q;

    logic              run_ok_c;
    logic              load_c;
    logic              dly_en_c;
    logic              xfer_en_c;
    logic              dly_end_c;
    logic              sample_c;
    logic              last_c;
    logic [ADDR_W-1:0] sched_addr;

    always_comb begin
        cfg_d            = '0;
        cfg_d.iterations = bus.iterations;
        cfg_d.period     = eff_period(bus.period);
        cfg_d.duty       = (bus.duty > cfg_d.period) ? cfg_d.period : bus.duty;
        cfg_d.delay      = bus.delay;
        cfg_d.incr       = bus.incr;
        cfg_d.shift      = bus.shift;
    end

    assign run_ok_c  = bus.run && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign load_c    = run_ok_c && (bus.iterations != '0);
    assign dly_en_c  = (state_q == ST_DLY) && !bus.pause;
    assign xfer_en_c = (state_q == ST_XFER) && !bus.pause;

    xwrite_sched u_sched (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_c),
        .dly_en_i  (dly_en_c),
        .xfer_en_i (xfer_en_c),
        .start_i   (bus.start),
        .cfg_i     (cfg_q),
        .dly_end_c (dly_end_c),
        .sample_c  (sample_c),
        .last_c    (last_c),
        .addr_o    (sched_addr)
    );

    // Control FSM plus the one-cycle output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_en_q <= sample_c;
            if (sample_c) begin
                mem_addr_q <= sched_addr;
                mem_data_q <= bus.flow_in;
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run_ok_c) begin
                        cfg_q <= cfg_d;
                        if (bus.iterations == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= (bus.delay == '0) ? ST_XFER : ST_DLY;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_DLY: begin
                    if (dly_end_c) state_q <= ST_XFER;
                end
                ST_XFER: begin
                    if (last_c) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
